// File: rtl/asmd_seq_multiplier_if.sv
// Request/response bundle between a controller and the ASMD sequential multiplier.
// The controller drives start and operands; the multiplier returns product and status.
interface asmd_seq_multiplier_if #(
    parameter int WORD_LENGTH = 8
);
    logic                       start;
    logic [WORD_LENGTH-1:0]     word0;
    logic [WORD_LENGTH-1:0]     word1;
    logic                       signed_mode;
    logic                       accumulate;
    logic [2*WORD_LENGTH-1:0]   product;
    logic                       ready;
    logic                       done;
    logic                       acc_overflow;

    modport master (
        output start, word0, word1, signed_mode, accumulate,
        input  product, ready, done, acc_overflow
    );

    modport slave (
        input  start, word0, word1, signed_mode, accumulate,
        output product, ready, done, acc_overflow
    );
endinterface

// File: rtl/asmd_seq_multiplier.sv
// Shift-add sequential multiplier: signed/unsigned, optional accumulate, early exit on the
// multiplier's highest set bit, one-cycle done pulse and sticky accumulate-overflow flag.
module asmd_seq_multiplier #(
    parameter int WORD_LENGTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    asmd_seq_multiplier_if.slave    bus
);
    localparam int PW = 2 * WORD_LENGTH;
    localparam int MW = WORD_LENGTH + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WORK   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    logic [1:0]     r_state;
    logic [PW-1:0]  r_mcand;
    logic [MW-1:0]  r_mplier;
    logic [PW-1:0]  r_partial;
    logic           r_sign;
    logic           r_acc;
    logic           r_signed;
    logic [PW-1:0]  r_product;
    logic           r_ready;
    logic           r_done;
    logic           r_ovf;

    logic           w_neg0;
    logic           w_neg1;
    logic [MW-1:0]  w_ext0;
    logic [MW-1:0]  w_ext1;
    logic [MW-1:0]  w_mag0;
    logic [MW-1:0]  w_mag1;
    logic [MW-1:0]  w_mplier_next;
    logic [PW-1:0]  w_result;
    logic [PW:0]    w_sum;
    logic           w_ovf;

    // One extra bit of magnitude so the most-negative operand negates without wrapping.
    assign w_neg0 = bus.signed_mode & bus.word0[WORD_LENGTH-1];
    assign w_neg1 = bus.signed_mode & bus.word1[WORD_LENGTH-1];
    assign w_ext0 = {w_neg0, bus.word0};
    assign w_ext1 = {w_neg1, bus.word1};
    assign w_mag0 = w_neg0 ? -w_ext0 : w_ext0;
    assign w_mag1 = w_neg1 ? -w_ext1 : w_ext1;

    assign w_mplier_next = r_mplier >> 1;
    assign w_result      = r_sign ? -r_partial : r_partial;
    assign w_sum         = {1'b0, r_product} + {1'b0, w_result};

    // Signed overflow: equal operand signs producing a sum of the other sign.
    assign w_ovf = r_signed
                 ? ((r_product[PW-1] == w_result[PW-1]) && (w_sum[PW-1] != r_product[PW-1]))
                 : w_sum[PW];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_partial <= '0;
            r_sign    <= 1'b0;
            r_acc     <= 1'b0;
            r_signed  <= 1'b0;
            r_product <= '0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_mcand   <= {{(PW-MW){1'b0}}, w_mag0};
                        r_mplier  <= w_mag1;
                        r_partial <= '0;
                        r_sign    <= w_neg0 ^ w_neg1;
                        r_acc     <= bus.accumulate;
                        r_signed  <= bus.signed_mode;
                        r_ready   <= 1'b0;
                        r_state   <= (w_mag1 != '0) ? ST_WORK : ST_FINISH;
                    end
                end
                ST_WORK: begin
                    if (r_mplier[0]) begin
                        r_partial <= r_partial + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_next;
                    // Leave as soon as no set bits remain above the current one.
                    if (w_mplier_next == '0) begin
                        r_state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    if (r_acc) begin
                        r_product <= w_sum[PW-1:0];
                        r_ovf     <= r_ovf | w_ovf;
                    end else begin
                        r_product <= w_result;
                        r_ovf     <= 1'b0;
                    end
                    r_ready <= 1'b1;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.product      = r_product;
    assign bus.ready        = r_ready;
    assign bus.done         = r_done;
    assign bus.acc_overflow = r_ovf;
endmodule

// File: tb/tb_asmd_seq_multiplier.sv
// Directed bench for asmd_seq_multiplier at WORD_LENGTH=4: vector table plus
// hand-written sequences for mid-op start, back-to-back and mid-op reset.
module tb_asmd_seq_multiplier;
    localparam int W = 4;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    asmd_seq_multiplier_if #(.WORD_LENGTH(W)) bus ();

    asmd_seq_multiplier #(.WORD_LENGTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   w0;
        logic [W-1:0]   w1;
        logic           sgn;
        logic           acc;
        logic [2*W-1:0] exp_p;
        logic           exp_ovf;
        int             exp_lat;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counts edges until done is seen, bounded.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.done && n < 30);
        if (!bus.done) begin
            compared++;
            mismatched++;
            $display("FAIL wait_done: got no done after %0d cycles expected done", n);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic acc, output int lat);
        bus.word0       = a;
        bus.word1       = b;
        bus.signed_mode = s;
        bus.accumulate  = acc;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat);
    endtask

    initial begin
        int  lat;
        int  n;
        bit  saw_done;

        compared   = 0;
        mismatched = 0;

        //          w0     w1     sgn   acc   product  ovf  lat
        vecs[0]  = '{4'h4, 4'h5, 1'b0, 1'b0, 8'h14, 1'b0, 4};
        vecs[1]  = '{4'hF, 4'hF, 1'b0, 1'b0, 8'hE1, 1'b0, 5};
        vecs[2]  = '{4'h8, 4'h3, 1'b1, 1'b0, 8'hE8, 1'b0, 3};
        vecs[3]  = '{4'h8, 4'h8, 1'b1, 1'b0, 8'h40, 1'b0, 5};
        vecs[4]  = '{4'h7, 4'hF, 1'b1, 1'b0, 8'hF9, 1'b0, 2};
        vecs[5]  = '{4'h3, 4'h4, 1'b0, 1'b0, 8'h0C, 1'b0, 4};
        vecs[6]  = '{4'h2, 4'h5, 1'b0, 1'b1, 8'h16, 1'b0, 4};
        vecs[7]  = '{4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1};
        vecs[8]  = '{4'hF, 4'hF, 1'b0, 1'b1, 8'hE1, 1'b0, 5};
        vecs[9]  = '{4'hF, 4'hF, 1'b0, 1'b1, 8'hC2, 1'b1, 5};
        vecs[10] = '{4'h1, 4'h1, 1'b0, 1'b0, 8'h01, 1'b0, 2};
        vecs[11] = '{4'h8, 4'h8, 1'b1, 1'b0, 8'h40, 1'b0, 5};
        vecs[12] = '{4'h8, 4'h8, 1'b1, 1'b1, 8'h80, 1'b1, 5};
        vecs[13] = '{4'h1, 4'h1, 1'b1, 1'b1, 8'h81, 1'b1, 2};
        vecs[14] = '{4'h5, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1};
        vecs[15] = '{4'hF, 4'h3, 1'b1, 1'b0, 8'hFD, 1'b0, 3};

        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.word0       = '0;
        bus.word1       = '0;
        bus.signed_mode = 1'b0;
        bus.accumulate  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_product", 32'(bus.product), 32'h0);
        check("reset_ready", 32'(bus.ready), 32'h1);
        check("reset_done", 32'(bus.done), 32'h0);
        check("reset_ovf", 32'(bus.acc_overflow), 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].w0, vecs[i].w1, vecs[i].sgn, vecs[i].acc, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_product", i), 32'(bus.product), 32'(vecs[i].exp_p));
            check($sformatf("vec%0d_ovf", i), 32'(bus.acc_overflow), 32'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_ready", i), 32'(bus.ready), 32'h1);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'h0);
            $display("vec%0d: %h x %h sgn=%0d acc=%0d -> product=%h ovf=%0d lat=%0d",
                     i, vecs[i].w0, vecs[i].w1, vecs[i].sgn, vecs[i].acc,
                     bus.product, bus.acc_overflow, lat);
        end

        // start pulsed mid-op with new operands must be ignored
        bus.word0 = 4'h4; bus.word1 = 4'h5; bus.signed_mode = 1'b0; bus.accumulate = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.word0 = 4'hF; bus.word1 = 4'hF; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("midstart_ready_low", 32'(bus.ready), 32'h0);
        wait_done(n);
        check("midstart_latency", 32'(n + 2), 32'd4);
        check("midstart_product", 32'(bus.product), 32'h14);
        repeat (3) @(posedge clk);
        #1;
        check("midstart_idle_ready", 32'(bus.ready), 32'h1);
        check("midstart_hold_product", 32'(bus.product), 32'h14);
        $display("midstart: product=%h ready=%0d", bus.product, bus.ready);

        // start held high through the op: accepted again on the done cycle
        bus.word0 = 4'h4; bus.word1 = 4'h5; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.word0 = 4'h3; bus.word1 = 4'h3;
        wait_done(n);
        check("b2b_first_latency", 32'(n), 32'd4);
        check("b2b_first_product", 32'(bus.product), 32'h14);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("b2b_second_accepted", 32'(bus.ready), 32'h0);
        check("b2b_done_cleared", 32'(bus.done), 32'h0);
        wait_done(n);
        check("b2b_second_latency", 32'(n), 32'd3);
        check("b2b_second_product", 32'(bus.product), 32'h09);
        $display("b2b: product=%h lat=%0d", bus.product, n);

        // reset mid-op clears product, flag and the op in flight
        run_op(4'h8, 4'h8, 1'b1, 1'b0, lat);
        run_op(4'h8, 4'h8, 1'b1, 1'b1, lat);
        check("prereset_ovf", 32'(bus.acc_overflow), 32'h1);
        @(posedge clk); #1;
        bus.word0 = 4'hF; bus.word1 = 4'hF; bus.signed_mode = 1'b0; bus.accumulate = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midreset_product", 32'(bus.product), 32'h0);
        check("midreset_ready", 32'(bus.ready), 32'h1);
        check("midreset_done", 32'(bus.done), 32'h0);
        check("midreset_ovf", 32'(bus.acc_overflow), 32'h0);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (bus.done) saw_done = 1'b1;
        end
        check("postreset_no_done", 32'(saw_done), 32'h0);
        check("postreset_product", 32'(bus.product), 32'h0);
        $display("midreset: product=%h ready=%0d ovf=%0d", bus.product, bus.ready, bus.acc_overflow);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/asmd_seq_multiplier.md
Name: asmd_seq_multiplier

Overview:
- Parametrised ASMD shift-add multiplier; next generation of the team's start/ready sequential multiplier.
- Adds signed (two's-complement) mode, multiply-accumulate mode, early termination on the multiplier's highest set bit, a one-cycle done pulse and a sticky accumulate-overflow flag.
- Sits as an arithmetic slave behind a controller that drives start/operands and waits on ready.

Parameters:
- WORD_LENGTH, 8, operand width in bits (>= 2); product width is 2*WORD_LENGTH.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  reset, synchronous, active-high.
- start  input  1  request; accepted only when ready=1.
- word0  input  WORD_LENGTH  multiplicand.
- word1  input  WORD_LENGTH  multiplier.
- signed_mode  input  1  1 = operands are two's complement; sampled with start.
- accumulate  input  1  1 = product <= product + result; 0 = product <= result; sampled with start.
- product  output  2*WORD_LENGTH  result register; changes only at op completion or reset.
- ready  output  1  idle, can accept start.
- done  output  1  one-cycle pulse, the cycle after product updates.
- acc_overflow  output  1  sticky overflow of accumulate addition.

Behaviour:
- Reset (sync, priority over everything): product=0, ready=1, done=0, acc_overflow=0, FSM=IDLE; aborts any op in progress, with no partial result written.
- FSM states: IDLE, WORK, FINISH.
- IDLE (ready=1): on start, latch the operands, signed_mode and accumulate.
  - Unsigned: magnitudes are word0/word1.
  - Signed: magnitudes are abs values (WORD_LENGTH+1-bit internal, so the most-negative value is handled); sign = msb(word0) XOR msb(word1).
  - ready<=0. Next state WORK if |word1| != 0, else FINISH.
- WORK: one multiplier bit per cycle, LSB first: if bit set, partial += multiplicand<<i.
  - Leaves for FINISH after k cycles, k = index of highest set bit of |word1| + 1.
  - Early termination: no cycles are spent on zero high bits.
- FINISH (1 cycle): result = sign ? -partial : partial, truncated to 2*WORD_LENGTH.
  - accumulate=0: product<=result; acc_overflow<=0.
  - accumulate=1: product<=product+result, modulo 2^(2*WORD_LENGTH).
    - Unsigned: acc_overflow sets on carry out.
    - Signed: acc_overflow sets when the operand signs are equal and the sum sign differs.
    - Sticky until reset or a non-accumulate op.
  - ready<=1; done<=1 for exactly one cycle; next IDLE.
- Latency: start accepted at edge E0; product/ready/done update at edge E(k+1). Range is 1 (zero multiplier) to WORD_LENGTH+1 cycles.
- start while ready=0: ignored; operands may change freely during an op without effect.
- start in the cycle done=1 (ready already 1): accepted normally; back-to-back ops allowed.
- Non-accumulate result is always exact: signed and unsigned products fit in 2*WORD_LENGTH.
- product holds its value between ops; never shows partial sums.

Test Plan:
- WORD_LENGTH=4, unsigned, 4x5.
  - product=8'd20; word1=0101 gives k=3, so ready high 4 cycles after the start edge; done pulses once.
- Unsigned 15x15.
  - product=8'hE1 (225) after 5 cycles (max latency).
- Signed -8x3 (4'h8, 4'h3).
  - product=8'hE8 (-24).
- Signed -8x-8.
  - product=8'h40 (64), with no corruption from the most-negative operand.
- Accumulate chain, unsigned.
  - 3x4 (acc=0), then 2x5 (acc=1): product=22, acc_overflow=0.
  - Then 15x15 (acc=1) twice after a plain 0x0: product=8'hC2 (450 mod 256), acc_overflow=1 after the second op.
  - A following non-accumulate op clears the flag.
- Boundaries:
  - word1=0: product=0 one cycle after start.
  - start pulsed again mid-op: ignored, and the first result is unchanged.
  - reset asserted mid-op: next cycle product=0, ready=1, done=0.
  - start held high on the done cycle: a second op starts immediately.
